// File: rtl/fetch_prefetch_queue_if.sv
// Instruction memory request/ready bus for the fetch prefetch queue.
// master = fetch side, slave = instruction memory.
interface fetch_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: sequential PC, imem handshake, prefetch FIFO, redirect flush.
// Define FETCH_PERF_CNT_EN to add perf_fetched / perf_flushed counters.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  fetch_prefetch_queue_if.master   imem,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_take,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state;
  state_t        state_nx;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fetch_pc;
  logic [31:0]   disc_addr;
  logic [31:0]   new_pc;
  logic          rsp;
  logic          hold;
  logic          push;
  logic          pop;

  assign rsp    = imem.imem_req && imem.imem_ready;
  assign hold   = imem.imem_req && !imem.imem_ready;
  assign push   = rsp && (state == REQ) && !redirect;
  assign pop    = instr_take && (count != '0) && !redirect;
  assign new_pc = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!redirect && start) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          state_nx = hold ? DISCARD : REQ;
        end
      end
      DISCARD: begin
        if (imem.imem_ready) begin
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // DISCARD keeps presenting the abandoned address until memory takes it.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = fetch_pc;
    unique case (state)
      IDLE: ;
      REQ: begin
        imem.imem_req = (count < FULL);
      end
      DISCARD: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = disc_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fetch_pc  <= RESET_PC;
      disc_addr <= RESET_PC;
    end else if (redirect) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= new_pc;
      if ((state == REQ) && hold) begin
        disc_addr <= fetch_pc;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {fetch_pc, imem.imem_rdata};
    end
  end

  assign head        = mem[rd_ptr];
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_inc;

  // Flushed entries on redirect plus any response that gets thrown away.
  always_comb begin
    flush_inc = '0;
    if (redirect) begin
      flush_inc = 32'(count);
    end
    if (rsp && (redirect || (state == DISCARD))) begin
      flush_inc = flush_inc + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      perf_flushed <= perf_flushed + flush_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a variable-latency memory.
// Perf counter checks are active when FETCH_PERF_CNT_EN is defined.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        start;
  logic        instr_take;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int errors;
  int checks;
  int latency;
  int wait_cnt;
  bit acc_prev;

  fetch_prefetch_queue_if bus ();

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .imem        (bus),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_take  (instr_take),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .count       (count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory: ready after `latency` waiting cycles of a held request.
  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    wait_cnt = 0;
    acc_prev = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.imem_req) begin
        if (acc_prev) wait_cnt = 0;
        bus.imem_ready = (wait_cnt >= latency);
        acc_prev = bus.imem_ready;
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        acc_prev = 1'b0;
        bus.imem_ready = 1'b0;
      end
      bus.imem_rdata = word(bus.imem_addr);
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    instr_take = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    latency = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_imem got=%0h want=0", {bus.imem_req, bus.imem_addr});
    end
    checks++;
    if ({instr_valid, instr, instr_pc, count} !== '0) begin
      errors++;
      $display("FAIL rst_out got v=%0b i=%h pc=%h c=%0d want 0",
               instr_valid, instr, instr_pc, count);
    end
  endtask

  task automatic test_stream();
    logic [64:0] exp;
    logic [64:0] got;
    do_reset();
    instr_take = 1'b1;
    kick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL start_req got=%h want=100000000",
               {bus.imem_req, bus.imem_addr});
    end
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, 32'(i * 4), word(32'(i * 4))};
      got = {instr_valid, instr_pc, instr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stream%0d got=%h want=%h", i, got, exp);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    kick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.imem_req, bus.imem_addr, count} !==
          {1'b1, 32'(i * 4), 3'(i)}) begin
        errors++;
        $display("FAIL fill%0d got req=%0b a=%h c=%0d want a=%h c=%0d",
                 i, bus.imem_req, bus.imem_addr, count, i * 4, i);
      end
      @(negedge clock);
    end
    checks++;
    if ({bus.imem_req, count, instr_pc} !== {1'b0, 3'd4, 32'h0}) begin
      errors++;
      $display("FAIL full got req=%0b c=%0d pc=%h want 0 4 0",
               bus.imem_req, count, instr_pc);
    end
    instr_take = 1'b1;
    @(negedge clock);
    instr_take = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr, count} !== {1'b1, 32'h10, 3'd3}) begin
      errors++;
      $display("FAIL refill got req=%0b a=%h c=%0d want 1 10 3",
               bus.imem_req, bus.imem_addr, count);
    end
    checks++;
    if ({instr_pc, instr} !== {32'h4, word(32'h4)}) begin
      errors++;
      $display("FAIL popped_head got pc=%h i=%h want 4", instr_pc, instr);
    end
    @(negedge clock);
    checks++;
    if ({bus.imem_req, count} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL refull got req=%0b c=%0d want 0 4", bus.imem_req, count);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'd5) begin
      errors++;
      $display("FAIL perf_fetched got=%0d want=5", perf_fetched);
    end
`endif
  endtask

  task automatic test_discard();
    int bad;
    logic [64:0] got;
    do_reset();
    latency = 3;
    kick();
    for (int k = 0; k < 50; k++) begin
      if (count == 3'd2) break;
      @(negedge clock);
    end
    checks++;
    if ({count, bus.imem_req, bus.imem_addr} !== {3'd2, 1'b1, 32'h8}) begin
      errors++;
      $display("FAIL disc_pre got c=%0d req=%0b a=%h want 2 1 8",
               count, bus.imem_req, bus.imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clock);
    redirect = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.imem_addr === 32'h100) break;
      if (instr_valid !== 1'b0 || bus.imem_addr !== 32'h8 ||
          bus.imem_req !== 1'b1) bad++;
      @(negedge clock);
    end
    checks++;
    if (bus.imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL disc_exit got a=%h want 100", bus.imem_addr);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL disc_hold got bad=%0d want 0", bad);
    end
    for (int k = 0; k < 30; k++) begin
      if (instr_valid === 1'b1) break;
      @(negedge clock);
    end
    got = {instr_valid, instr_pc, instr};
    checks++;
    if (got !== {1'b1, 32'h100, word(32'h100)}) begin
      errors++;
      $display("FAIL disc_new got=%h want pc=100", got);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_flushed !== 32'd3) begin
      errors++;
      $display("FAIL disc_flushed got=%0d want=3", perf_flushed);
    end
`endif
  endtask

  task automatic test_redirect_ready();
    do_reset();
    instr_take = 1'b1;
    kick();
    repeat (3) @(negedge clock);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clock);
    redirect = 1'b0;
    checks++;
    if ({instr_valid, count, bus.imem_req, bus.imem_addr} !==
        {1'b0, 3'd0, 1'b1, 32'h200}) begin
      errors++;
      $display("FAIL redir_flush got v=%0b c=%0d req=%0b a=%h want 0 0 1 200",
               instr_valid, count, bus.imem_req, bus.imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_flushed !== 32'd2) begin
      errors++;
      $display("FAIL redir_flushed got=%0d want=2", perf_flushed);
    end
`endif
    @(negedge clock);
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h200, word(32'h200)}) begin
      errors++;
      $display("FAIL redir_new got v=%0b pc=%h want 1 200",
               instr_valid, instr_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clock);
    redirect = 1'b0;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL idle_redir got req=%0b a=%h want 0 fffffffc",
               bus.imem_req, bus.imem_addr);
    end
    kick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_req got a=%h want fffffffc", bus.imem_addr);
    end
    @(negedge clock);
    checks++;
    if ({bus.imem_addr, count, instr_pc} !== {32'h0, 3'd1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL wrap_next got a=%h c=%0d pc=%h want 0 1 fffffffc",
               bus.imem_addr, count, instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    latency = 3;
    kick();
    for (int k = 0; k < 50; k++) begin
      if (count == 3'd2) break;
      @(negedge clock);
    end
    checks++;
    if ({count, bus.imem_req} !== {3'd2, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre got c=%0d req=%0b want 2 1", count, bus.imem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr, instr_valid, instr, instr_pc, count}
        !== '0) begin
      errors++;
      $display("FAIL mid_rst got req=%0b a=%h v=%0b i=%h pc=%h c=%0d want 0",
               bus.imem_req, bus.imem_addr, instr_valid, instr, instr_pc,
               count);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({perf_fetched, perf_flushed} !== 64'h0) begin
      errors++;
      $display("FAIL mid_perf got f=%0d x=%0d want 0",
               perf_fetched, perf_flushed);
    end
`endif
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    start = 1'b0;
    instr_take = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    latency = 0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_discard();
    test_redirect_ready();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
